// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared definitions for the multi-cycle RV32M divide/remainder unit.
//   - DIV_OP encodings and a decoder returning signedness and quotient/remainder select.
//   - FSM state enumeration.
//   - RV32 constants for the special-case results (most negative value, all ones).
package seq_divider_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_SIGN,
    S_FIN
  } state_e;

  localparam logic [31:0] MIN_NEG  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef struct packed {
    logic is_signed;
    logic is_rem;
  } op_dec_t;

  function automatic op_dec_t decode_op(input logic [1:0] op);
    op_dec_t d;
    d = '0;
    unique case (op)
      OP_DIV:  begin d.is_signed = 1'b1; d.is_rem = 1'b0; end
      OP_DIVU: begin d.is_signed = 1'b0; d.is_rem = 1'b0; end
      OP_REM:  begin d.is_signed = 1'b1; d.is_rem = 1'b1; end
      OP_REMU: begin d.is_signed = 1'b0; d.is_rem = 1'b1; end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one combinational radix-2 restoring division iteration.
//   rem_i     partial remainder (WIDTH+1 bits)
//   quot_i    dividend/quotient shift register
//   divisor_i divisor magnitude
//   rem_o     partial remainder after shift and trial subtract
//   quot_o    quotient shifted left with the new quotient bit in the LSB
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quot_o
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;
  logic           borrow;
  logic           fits;

  // Shift {rem, quot} left by one: the dividend MSB moves into the remainder.
  assign rem_sh = {rem_i[WIDTH-1:0], quot_i[WIDTH-1]};

  assign {borrow, diff} = {1'b0, rem_sh} - {2'b00, divisor_i};

  // A set remainder MSB means the shifted value already exceeds any divisor.
  assign fits   = rem_i[WIDTH] | ~borrow;

  assign rem_o  = fits ? diff : rem_sh;
  assign quot_o = {quot_i[WIDTH-2:0], fits};

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle RV32M DIV/DIVU/REM/REMU unit (restoring, one quotient bit per cycle).
//   clk_i      rising-edge clock
//   rst_ni     asynchronous active-low reset
//   start_i    request, sampled only while idle
//   div_op_i   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   data1_i    dividend
//   data2_i    divisor
//   flush_i    synchronous abort of the in-flight operation
//   busy_o     high in every state except idle
//   done_o     one-cycle pulse, result_o valid
//   result_o   quotient or remainder; holds until the next result load
// Optional feature: define DIV_PAIR_CACHE_EN to keep the operands and results of the last
// normally completed operation so a repeat of the same operand pair finishes in one cycle.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       div_op_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam logic [WIDTH-1:0] MinNegW   = WIDTH'(MIN_NEG);
  localparam logic [WIDTH-1:0] AllOnesW  = WIDTH'(ALL_ONES);
  localparam logic [CNT_W-1:0] LastIter  = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             is_rem_q, is_rem_d;
  logic [WIDTH-1:0] result_q, result_d;

  op_dec_t          dec;
  logic             accept;
  logic             div_zero;
  logic             sgn_ovf;
  logic             special;
  logic [WIDTH-1:0] special_res;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH-1:0] quot_final, rem_final;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quot;
  logic             cache_hit;
  logic [WIDTH-1:0] cache_res;

  assign dec      = decode_op(div_op_i);
  assign accept   = (state_q == S_IDLE) && start_i && !flush_i;
  assign div_zero = (data2_i == '0);
  assign sgn_ovf  = dec.is_signed && (data1_i == MinNegW) && (data2_i == AllOnesW);
  assign special  = div_zero || sgn_ovf;

  // Divide by zero is checked first so it wins over signed overflow.
  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = dec.is_rem ? data1_i : AllOnesW;
    end else begin
      special_res = dec.is_rem ? '0 : MinNegW;
    end
  end

  assign mag1 = (dec.is_signed && data1_i[WIDTH-1]) ? -data1_i : data1_i;
  assign mag2 = (dec.is_signed && data2_i[WIDTH-1]) ? -data2_i : data2_i;

  assign quot_final = qneg_q ? -quot_q : quot_q;
  assign rem_final  = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_i     (rem_q),
    .quot_i    (quot_q),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .quot_o    (step_quot)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    dvsr_d   = dvsr_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    is_rem_d = is_rem_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          is_rem_d = dec.is_rem;
          if (special) begin
            result_d = special_res;
            state_d  = S_FIN;
          end else if (cache_hit) begin
            result_d = cache_res;
            state_d  = S_FIN;
          end else begin
            rem_d   = '0;
            quot_d  = mag1;
            dvsr_d  = mag2;
            qneg_d  = dec.is_signed & (data1_i[WIDTH-1] ^ data2_i[WIDTH-1]);
            rneg_d  = dec.is_signed & data1_i[WIDTH-1];
            cnt_d   = '0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          rem_d  = step_rem;
          quot_d = step_quot;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LastIter) begin
            state_d = S_SIGN;
          end
        end
      end
      S_SIGN: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          result_d = is_rem_q ? rem_final : quot_final;
          state_d  = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      dvsr_q   <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      is_rem_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      dvsr_q   <= dvsr_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      is_rem_q <= is_rem_d;
      result_q <= result_d;
    end
  end

`ifdef DIV_PAIR_CACHE_EN
  logic             cache_vld_q, cache_vld_d;
  logic [WIDTH-1:0] key_a_q, key_a_d;
  logic [WIDTH-1:0] key_b_q, key_b_d;
  logic             key_sgn_q, key_sgn_d;
  logic [WIDTH-1:0] hit_quot_q, hit_quot_d;
  logic [WIDTH-1:0] hit_rem_q, hit_rem_d;
  logic [WIDTH-1:0] cur_a_q, cur_a_d;
  logic [WIDTH-1:0] cur_b_q, cur_b_d;
  logic             cur_sgn_q, cur_sgn_d;
  logic             cur_norm_q, cur_norm_d;

  assign cache_hit = cache_vld_q && (key_a_q == data1_i) && (key_b_q == data2_i) &&
                     (key_sgn_q == dec.is_signed);
  assign cache_res = dec.is_rem ? hit_rem_q : hit_quot_q;

  always_comb begin
    cache_vld_d = cache_vld_q;
    key_a_d     = key_a_q;
    key_b_d     = key_b_q;
    key_sgn_d   = key_sgn_q;
    hit_quot_d  = hit_quot_q;
    hit_rem_d   = hit_rem_q;
    cur_a_d     = cur_a_q;
    cur_b_d     = cur_b_q;
    cur_sgn_d   = cur_sgn_q;
    cur_norm_d  = cur_norm_q;

    // Raw operands are kept because the key must match the request, not the magnitudes.
    if (accept) begin
      cur_a_d    = data1_i;
      cur_b_d    = data2_i;
      cur_sgn_d  = dec.is_signed;
      cur_norm_d = !special && !cache_hit;
    end

    if ((state_q == S_SIGN) && !flush_i) begin
      cache_vld_d = 1'b1;
      key_a_d     = cur_a_q;
      key_b_d     = cur_b_q;
      key_sgn_d   = cur_sgn_q;
      hit_quot_d  = quot_final;
      hit_rem_d   = rem_final;
    end

    if (flush_i && cur_norm_q && (state_q != S_IDLE)) begin
      cache_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cache_vld_q <= 1'b0;
      key_a_q     <= '0;
      key_b_q     <= '0;
      key_sgn_q   <= 1'b0;
      hit_quot_q  <= '0;
      hit_rem_q   <= '0;
      cur_a_q     <= '0;
      cur_b_q     <= '0;
      cur_sgn_q   <= 1'b0;
      cur_norm_q  <= 1'b0;
    end else begin
      cache_vld_q <= cache_vld_d;
      key_a_q     <= key_a_d;
      key_b_q     <= key_b_d;
      key_sgn_q   <= key_sgn_d;
      hit_quot_q  <= hit_quot_d;
      hit_rem_q   <= hit_rem_d;
      cur_a_q     <= cur_a_d;
      cur_b_q     <= cur_b_d;
      cur_sgn_q   <= cur_sgn_d;
      cur_norm_q  <= cur_norm_d;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_res = '0;
`endif

  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = (state_q == S_FIN);
  assign result_o = result_q;

endmodule

// File: tb/tb_seq_divider.sv
// Testbench for seq_divider: directed cases with literal expectations plus randomized traffic
// checked every cycle against an arithmetic reference model of the divider's observable timing.
module tb_seq_divider;
  import seq_divider_pkg::*;

`ifdef DIV_PAIR_CACHE_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 34;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] d1, d2;
  logic        flush;
  logic        busy, done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  seq_divider #(
    .WIDTH (32),
    .CNT_W (6)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .div_op_i (op),
    .data1_i  (d1),
    .data2_i  (d2),
    .flush_i  (flush),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    logic   sgn, is_rem;
    sgn    = (o == OP_DIV) || (o == OP_REM);
    is_rem = (o == OP_REM) || (o == OP_REMU);
    if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      // 64-bit arithmetic makes the signed-overflow case fall out naturally.
      return is_rem ? 32'(sa % sb) : 32'(sa / sb);
    end
    return is_rem ? (a % b) : (a / b);
  endfunction

  function automatic logic is_special(input logic [1:0] o, input logic [31:0] a,
                                      input logic [31:0] b);
    logic sgn;
    sgn = (o == OP_DIV) || (o == OP_REM);
    return (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  bit          m_busy, m_done, m_norm;
  int          m_left;
  logic [31:0] m_res, m_pend;
  bit          mc_vld;
  logic [31:0] mc_a, mc_b, m_a, m_b;
  bit          mc_sgn, m_sgn;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_left = 0; m_res = '0; mc_vld = 0; m_norm = 0;
    end else if (m_busy) begin
      if (flush || m_done) begin
        if (flush && m_norm) mc_vld = 0;
        m_busy = 0;
        m_done = 0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1;
          m_res  = m_pend;
          if (m_norm) begin
            mc_vld = 1; mc_a = m_a; mc_b = m_b; mc_sgn = m_sgn;
          end
        end
      end
    end else if (start && !flush) begin
      m_pend = ref_div(op, d1, d2);
      m_a    = d1;
      m_b    = d2;
      m_sgn  = (op == OP_DIV) || (op == OP_REM);
      m_norm = 0;
      if (is_special(op, d1, d2)) m_left = 0;
`ifdef DIV_PAIR_CACHE_EN
      else if (mc_vld && mc_a == d1 && mc_b == d2 && mc_sgn == m_sgn) m_left = 0;
`endif
      else begin
        m_left = 33;
        m_norm = 1;
      end
      m_busy = 1;
      if (m_left == 0) begin
        m_done = 1;
        m_res  = m_pend;
      end
    end
  end

  // Cycle-by-cycle comparison of all outputs against the model.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("result", result, m_res);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    int busy_low;
    start = 1'b1; op = o; d1 = a; d2 = b;
    tick();
    start = 1'b0;
    lat = 0;
    busy_low = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!busy) busy_low++;
    end while (!done && lat < 100);
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_result"}, result, exp);
    check({name, "_busy_low_cycles"}, 32'(busy_low), 32'd0);
    tick();
  endtask

  function automatic logic [31:0] pick();
    unique case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      4: return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; d1 = '0; d2 = '0;
    #2;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    #20 rst_n = 1'b1;
    tick();

    // Pin the reference model with hand-computed values.
    check("model_div_neg", ref_div(OP_DIV, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    check("model_rem_neg", ref_div(OP_REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    check("model_ovf_div", ref_div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    check("model_ovf_rem", ref_div(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);
    check("model_remu_zero", ref_div(OP_REMU, 32'd5, 32'd0), 32'd5);

    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, HIT_LAT);
    run_op("divu_max_3", OP_DIVU, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 34);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 34);

    // Flush on cycle 10 of a DIVU: no DONE, idle next cycle, RESULT unchanged.
    start = 1'b1; op = OP_DIVU; d1 = 32'd12345; d2 = 32'd67;
    tick();
    start = 1'b0;
    repeat (8) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy_next", 32'(busy), 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("flush_no_done", 32'(ndone), 32'd0);
    check("flush_result_kept", result, 32'd2);
    tick();
    run_op("divu_after_flush", OP_DIVU, 32'd1000, 32'd10, 32'd100, 34);

    run_op("div_by_zero", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu_by_zero", OP_REMU, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_overflow", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // A second, different START while busy is ignored.
    start = 1'b1; op = OP_DIVU; d1 = 32'd999; d2 = 32'd9;
    tick();
    start = 1'b0;
    repeat (3) tick();
    start = 1'b1; op = OP_DIV; d1 = 32'd77; d2 = 32'd7;
    tick();
    start = 1'b0;
    repeat (40) tick();
    check("busy_start_ignored_result", result, 32'd111);
    check("busy_start_ignored_idle", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of CALC.
    start = 1'b1; op = OP_DIVU; d1 = 32'd500; d2 = 32'd5;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    check("midreset_result", result, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    run_op("div_1000_7", OP_DIV, 32'd1000, 32'd7, 32'd142, 34);
    run_op("rem_1000_7", OP_REM, 32'd1000, 32'd7, 32'd6, HIT_LAT);

    // Randomized traffic, including starts while busy, flushes and repeated operand pairs.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      op    = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) begin
        d1 = pick();
        d2 = pick();
      end
      flush = ($urandom_range(0, 59) == 0);
      tick();
    end
    start = 1'b0;
    flush = 1'b0;
    repeat (40) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
